// File: rtl/synth_pkg.sv
// Shared encodings and default widths for the single-voice sample source.
package synth_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int PHASE_W_DEF  = 24;
  localparam int ENV_W_DEF    = 8;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_OFF    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ENV_OFF     = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_e;

  typedef enum logic [1:0] {
    SEQ_ADV   = 2'd0,
    SEQ_SCALE = 2'd1,
    SEQ_HOLD  = 2'd2
  } seq_e;
endpackage

// File: rtl/synth_voice_if.sv
// Sample stream toward the I2S serializer: valid/ready handshake carrying one signed PCM sample.
interface synth_voice_if #(parameter int SAMPLE_W = synth_pkg::SAMPLE_W_DEF);
  logic                       s_valid;
  logic                       s_ready;
  logic signed [SAMPLE_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/synth_env.sv
// Attack/sustain/release envelope with saturating level; advances only on i_adv.
// Level and state update one cycle after the strobe; o_retrig is combinational on the strobe.
module synth_env
  import synth_pkg::*;
#(
  parameter int ENV_W = ENV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_gate,
  input  logic [ENV_W-1:0] i_attack_step,
  input  logic [ENV_W-1:0] i_release_step,
  output logic [ENV_W-1:0] o_level,
  output env_e             o_state,
  output logic             o_retrig
);
  localparam logic [ENV_W-1:0] LVL_MAX = '1;

  logic [ENV_W-1:0] r_level;
  env_e             r_state;
  logic [ENV_W:0]   w_att_sum;
  logic [ENV_W-1:0] w_att_lvl, w_rel_lvl, w_nxt_lvl;
  env_e             w_att_st, w_rel_st, w_nxt_st;

  // Level is 0 whenever OFF, so the attack path also covers the OFF->ATTACK start.
  assign w_att_sum = {1'b0, r_level} + {1'b0, i_attack_step};

  always_comb begin
    w_att_lvl = LVL_MAX;
    w_att_st  = ENV_SUSTAIN;
    if (i_attack_step != '0 && w_att_sum < {1'b0, LVL_MAX}) begin
      w_att_lvl = w_att_sum[ENV_W-1:0];
      w_att_st  = ENV_ATTACK;
    end
    w_rel_lvl = '0;
    w_rel_st  = ENV_OFF;
    if (i_release_step != '0 && r_level > i_release_step) begin
      w_rel_lvl = r_level - i_release_step;
      w_rel_st  = ENV_RELEASE;
    end
    w_nxt_lvl = r_level;
    w_nxt_st  = r_state;
    case (r_state)
      ENV_OFF:     if (i_gate) begin w_nxt_lvl = w_att_lvl; w_nxt_st = w_att_st; end
      ENV_ATTACK:  begin
        w_nxt_lvl = i_gate ? w_att_lvl : w_rel_lvl;
        w_nxt_st  = i_gate ? w_att_st  : w_rel_st;
      end
      ENV_SUSTAIN: if (!i_gate) begin w_nxt_lvl = w_rel_lvl; w_nxt_st = w_rel_st; end
      ENV_RELEASE: begin
        w_nxt_lvl = i_gate ? w_att_lvl : w_rel_lvl;
        w_nxt_st  = i_gate ? w_att_st  : w_rel_st;
      end
      default:     begin w_nxt_lvl = '0; w_nxt_st = ENV_OFF; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
      r_state <= ENV_OFF;
    end else if (i_adv) begin
      r_level <= w_nxt_lvl;
      r_state <= w_nxt_st;
    end
  end

  assign o_level  = r_level;
  assign o_state  = r_state;
  assign o_retrig = i_adv && (r_state == ENV_OFF) && i_gate;
endmodule

// File: rtl/synth_voice.sv
// Phase-accumulator oscillator scaled by an ASR envelope; one sample per accepted handshake.
// Three-cycle minimum per sample (ADV, SCALE, HOLD); s_data/s_valid hold while s_ready is low.
module synth_voice
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int ENV_W    = ENV_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic               gate,
  input  logic [ENV_W-1:0]   attack_step,
  input  logic [ENV_W-1:0]   release_step,
  synth_voice_if.master      s,
  output logic [ENV_W-1:0]   env_level,
  output logic [1:0]         env_state
);
  localparam logic signed [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

  seq_e                       r_seq;
  logic [PHASE_W-1:0]         r_phase;
  logic signed [SAMPLE_W-1:0] r_raw;

  logic                       w_adv, w_retrig;
  env_e                       w_env_state;
  logic [PHASE_W-1:0]         w_phase_cur;
  logic [SAMPLE_W-1:0]        w_u, w_fold, w_tri_sh;
  logic signed [SAMPLE_W-1:0] w_raw, w_scaled;
  logic signed [SAMPLE_W+ENV_W:0] w_prod;

  assign w_adv = (r_seq == SEQ_ADV);

  synth_env #(.ENV_W(ENV_W)) u_env (
    .clk            (clk),
    .rst            (rst),
    .i_adv          (w_adv),
    .i_gate         (gate),
    .i_attack_step  (attack_step),
    .i_release_step (release_step),
    .o_level        (env_level),
    .o_state        (w_env_state),
    .o_retrig       (w_retrig)
  );
  assign env_state = w_env_state;

  // A note-on from OFF restarts the waveform at phase 0 for this very sample.
  assign w_phase_cur = w_retrig ? '0 : r_phase;
  assign w_u         = w_phase_cur[PHASE_W-1 -: SAMPLE_W];
  assign w_fold      = w_u[SAMPLE_W-1] ? ~w_u : w_u;
  assign w_tri_sh    = w_fold << 1;

  always_comb begin
    w_raw = '0;
    case (wave_sel)
      WAVE_SAW:    w_raw = {~w_u[SAMPLE_W-1], w_u[SAMPLE_W-2:0]};
      WAVE_SQUARE: w_raw = w_u[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
      WAVE_TRI:    w_raw = {~w_tri_sh[SAMPLE_W-1], w_tri_sh[SAMPLE_W-2:0]};
      default:     w_raw = '0;
    endcase
  end

  assign w_prod   = r_raw * $signed({1'b0, env_level});
  assign w_scaled = SAMPLE_W'(w_prod >>> ENV_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq     <= SEQ_ADV;
      r_phase   <= '0;
      r_raw     <= '0;
      s.s_valid <= 1'b0;
      s.s_data  <= '0;
    end else begin
      case (r_seq)
        SEQ_ADV: begin
          r_raw   <= w_raw;
          r_phase <= w_phase_cur + phase_inc;
          r_seq   <= SEQ_SCALE;
        end
        SEQ_SCALE: begin
          s.s_data  <= w_scaled;
          s.s_valid <= 1'b1;
          r_seq     <= SEQ_HOLD;
        end
        SEQ_HOLD: begin
          if (s.s_ready) begin
            s.s_valid <= 1'b0;
            r_seq     <= SEQ_ADV;
          end
        end
        default: r_seq <= SEQ_ADV;
      endcase
    end
  end
endmodule

// File: tb/tb_synth_voice.sv
// Directed bench for synth_voice: reset, waveforms, envelope, backpressure, async reset.
module tb_synth_voice;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] phase_inc = '0;
  logic [1:0]  wave_sel = WAVE_SAW;
  logic        gate = 1'b0;
  logic [7:0]  attack_step = '0;
  logic [7:0]  release_step = '0;
  logic [7:0]  env_level;
  logic [1:0]  env_state;

  synth_voice_if #(.SAMPLE_W(16)) bus();

  synth_voice dut (
    .clk          (clk),
    .rst          (rst),
    .phase_inc    (phase_inc),
    .wave_sel     (wave_sel),
    .gate         (gate),
    .attack_step  (attack_step),
    .release_step (release_step),
    .s            (bus),
    .env_level    (env_level),
    .env_state    (env_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] d;
  logic [7:0]         l;
  logic [1:0]         st;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!bus.s_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("vld_wait", longint'(bus.s_valid), 1);
  endtask

  // Waits for a sample, captures it, and lets the next rising edge consume it (s_ready must be 1).
  task automatic get_sample();
    wait_vld();
    d  = bus.s_data;
    l  = env_level;
    st = env_state;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input logic [1:0] ws, input logic [23:0] inc,
                       input logic [7:0] att, input logic [7:0] rel, input logic g);
    rst          = 1'b0;
    bus.s_ready  = 1'b1;
    wave_sel     = ws;
    phase_inc    = inc;
    attack_step  = att;
    release_step = rel;
    gate         = g;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int exp_sq[4]  = '{32639, 32639, -32640, -32640};
  int exp_saw[8] = '{-32640, -24480, -16320, -8160, 0, 8160, 16320, 24480};
  int exp_tri[4] = '{-32640, 0, 32638, -2};
  int exp_att[4] = '{64, 128, 192, 255};
  int exp_ast[4] = '{1, 1, 1, 2};
  int exp_rel[3] = '{155, 55, 0};
  int exp_rst[3] = '{3, 3, 0};

  initial begin
    int nv;
    bus.s_ready = 1'b1;

    // 1: reset state, latency, rate, silence with gate low
    @(negedge clk);
    chk("rst_vld", longint'(bus.s_valid), 0);
    chk("rst_data", longint'(bus.s_data), 0);
    chk("rst_lvl", longint'(env_level), 0);
    chk("rst_state", longint'(env_state), ENV_OFF);
    phase_inc = 24'h100000;
    rst = 1'b1;
    @(negedge clk);
    chk("lat_edge1", longint'(bus.s_valid), 0);
    @(negedge clk);
    chk("lat_edge2", longint'(bus.s_valid), 1);
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.s_valid) nv++;
      @(negedge clk);
    end
    chk("vld_rate", nv, 10);
    for (int i = 0; i < 20; i++) begin
      get_sample();
      chk("silent_data", longint'(d), 0);
    end
    chk("silent_state", longint'(st), ENV_OFF);

    // 2: square at full level
    start(WAVE_SQUARE, 24'h400000, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      get_sample();
      chk("sq_data", longint'(d), exp_sq[i % 4]);
      if (i == 0) begin
        chk("sq_lvl", longint'(l), 255);
        chk("sq_state", longint'(st), ENV_SUSTAIN);
      end
    end

    // 3: saw wraps every 8 samples
    start(WAVE_SAW, 24'h200000, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      get_sample();
      chk("saw_data", longint'(d), exp_saw[i % 8]);
    end

    // triangle corners
    start(WAVE_TRI, 24'h400000, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      get_sample();
      chk("tri_data", longint'(d), exp_tri[i]);
    end

    // 4: attack then release on a constant square (phase_inc 0)
    start(WAVE_SQUARE, 24'h0, 8'd64, 8'd100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      get_sample();
      chk("att_lvl", longint'(l), exp_att[i]);
      chk("att_state", longint'(st), exp_ast[i]);
      if (i == 0) chk("att_data", longint'(d), 8191);
    end
    gate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      get_sample();
      chk("rel_lvl", longint'(l), exp_rel[i]);
      chk("rel_state", longint'(st), exp_rst[i]);
    end

    // 5: backpressure holds the third saw sample
    start(WAVE_SAW, 24'h200000, 8'd0, 8'd0, 1'b1);
    get_sample();
    get_sample();
    bus.s_ready = 1'b0;
    wait_vld();
    chk("bp_first", longint'(bus.s_data), -16320);
    repeat (10) @(negedge clk);
    chk("bp_vld", longint'(bus.s_valid), 1);
    chk("bp_data", longint'(bus.s_data), -16320);
    chk("bp_lvl", longint'(env_level), 255);
    bus.s_ready = 1'b1;
    get_sample();
    chk("bp_taken", longint'(d), -16320);
    get_sample();
    chk("bp_next", longint'(d), -8160);

    // 6: asynchronous reset while holding a sample
    start(WAVE_SAW, 24'h200000, 8'd0, 8'd0, 1'b1);
    get_sample();
    get_sample();
    bus.s_ready = 1'b0;
    wait_vld();
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", longint'(bus.s_valid), 0);
    chk("arst_data", longint'(bus.s_data), 0);
    chk("arst_lvl", longint'(env_level), 0);
    chk("arst_state", longint'(env_state), ENV_OFF);
    @(negedge clk);
    bus.s_ready = 1'b1;
    rst = 1'b1;
    get_sample();
    chk("arst_first", longint'(d), -32640);
    get_sample();
    chk("arst_second", longint'(d), -24480);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
